mux_sel_pipe: RTL and testbench
===============================

Name: mux_sel_pipe

Overview:
Parametrised N-channel, WIDTH-bit selector with a registered output stage and a valid/ready handshake on the output. It is the successor of the datapath 5-way selectors and is used for the PC-source and ALU-operand selection paths.
- Two modes:
  - Direct: `controle` picks the channel.
  - Scan: round-robin over channels with `in_valid` set.
- Consumed inputs get a one-cycle acknowledge.
- Illegal select codes are flagged.

Parameters:
- WIDTH, 32, data width of every channel.
- N, 5, number of input channels (2..16).
- SEL_W, 3, width of `controle` and `out_sel`; must satisfy 2^SEL_W >= N.
- CONST_CH, 1, channel index replaced by a constant (used only with the optional feature).
- CONST_VAL, 32'd4, constant driven on CONST_CH (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N  per-channel data-valid.
- in_ack  out  N  one-hot, one-cycle pulse: channel consumed into the output register.
- controle  in  SEL_W  channel select, direct mode.
- mode  in  1  0 = direct, 1 = round-robin scan.
- out_ready  in  1  downstream accepts `out_data` this cycle.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  `out_data` holds an unconsumed word.
- out_sel  out  SEL_W  channel index that produced `out_data`.
- sel_err  out  1  last direct-mode load used `controle` >= N.

Behaviour:

Reset (synchronous; wins over every other event in the same cycle):
- `out_data`=0, `out_valid`=0, `out_sel`=0, `sel_err`=0, `in_ack`=0, scan pointer `ptr`=0.
- Reset asserted mid-transfer discards the held word; no `in_ack` is issued that cycle.

Load condition:
- load = !`out_valid` | `out_ready`, evaluated at the rising edge.
- !load (stall): `out_data`, `out_valid`, `out_sel`, `sel_err` and `ptr` hold; `in_ack`=0.
- Latency is 1 cycle from input sampling to `out_data`/`out_valid`.
- Full throughput: one word per cycle while `out_ready`=1.

Direct mode (`mode`=0), on load:
- `controle` < N and channel valid: `out_data` <= channel[`controle`], `out_valid` <= 1, `out_sel` <= `controle`, `in_ack`[`controle`] <= 1, `sel_err` <= 0.
- `controle` < N and channel not valid: `out_valid` <= 0, `out_data`/`out_sel` hold, `sel_err` <= 0.
- `controle` >= N: `out_valid` <= 0, `out_data`/`out_sel` hold, `in_ack`=0, `sel_err` <= 1.
  - `sel_err` stays high until the next load with a legal code.

Scan mode (`mode`=1), on load:
- Search channels ptr, ptr+1, …, N-1, 0, …, ptr-1; take the first with `in_valid` set.
- Found channel c: `out_data` <= channel[c], `out_valid` <= 1, `out_sel` <= c, `in_ack`[c] <= 1, `ptr` <= (c+1 == N) ? 0 : c+1.
- None valid: `out_valid` <= 0, `ptr` holds.
- `sel_err` <= 0 on every scan-mode load; `controle` is ignored.

General rules:
- A `mode` change takes effect at the next load; `ptr` is retained across mode changes.
- `in_ack` is asserted only in the cycle after the load that consumed the channel; at most one bit is ever set.
- Simultaneous `out_ready`=1 and a new valid channel: the old word is transferred and the new word is loaded in the same edge (no bubble).

Optional Feature:
Macro: MUX_SEL_PIPE_CONST_EN.
- Defined:
  - Channel CONST_CH ignores `in_data` and `in_valid[CONST_CH]`.
  - It always supplies CONST_VAL and is always valid.
  - `in_ack[CONST_CH]` still pulses when it is selected.
  - In scan mode CONST_CH is always a candidate, so `out_valid` never drops while `out_ready`=1.
- Undefined: CONST_CH is an ordinary channel; CONST_VAL is unused.

Test Plan:
1. Reset check: assert `reset` for 2 cycles with arbitrary inputs -> `out_data`=0, `out_valid`=0, `out_sel`=0, `sel_err`=0, `in_ack`=0.
2. Direct select with backpressure:
   - Stimulus: `mode`=0, `controle`=2, channel 2=0xDEADBEEF valid, `out_ready`=1.
   - Next cycle: `out_data`=0xDEADBEEF, `out_sel`=2, `in_ack`=5'b00100.
   - Then hold `out_ready`=0 for 3 cycles -> outputs frozen, `in_ack`=0.
3. Illegal select: `controle`=6 with N=5 -> `out_valid`=0, `sel_err`=1, `out_data` unchanged; then `controle`=0 with valid data -> `sel_err`=0.
4. Scan fairness: `mode`=1, channels 0, 3, 4 valid, `out_ready`=1 -> `out_sel` sequence 0, 3, 4, 0, 3 and `in_ack` one-hot matching each.
5. Optional feature: with MUX_SEL_PIPE_CONST_EN, `controle`=1 and `in_data` channel 1=0xFFFFFFFF, `in_valid`[1]=0 -> `out_data`=4, `out_valid`=1; without the macro -> `out_valid`=0.
6. Reset during stall: `out_valid`=1, `out_ready`=0, `reset`=1 -> next cycle `out_valid`=0, `ptr`=0; the first scan after reset starts at channel 0.

Source files
------------

// File: rtl/mux_sel_pipe.sv
// N-channel registered selector with valid/ready output, direct and round-robin scan modes.
// Optional build macro MUX_SEL_PIPE_CONST_EN ties channel CONST_CH to the always-valid constant CONST_VAL.
module mux_sel_pipe #(
  parameter int               WIDTH     = 32,
  parameter int               N         = 5,
  parameter int               SEL_W     = 3,
  parameter int               CONST_CH  = 1,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(4)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ack,
  input  logic [SEL_W-1:0]     controle,
  input  logic                 mode,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 sel_err
);

  // Channel table padded to the full select range so any code indexes safely.
  localparam int DEPTH = 2 ** SEL_W;

  logic [WIDTH-1:0] ch_data [DEPTH];
  logic [DEPTH-1:0] ch_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ch
    if (k >= N) begin : g_pad
      assign ch_data[k]  = '0;
      assign ch_valid[k] = 1'b0;
    end
`ifdef MUX_SEL_PIPE_CONST_EN
    else if (k == CONST_CH) begin : g_const
      assign ch_data[k]  = CONST_VAL;
      assign ch_valid[k] = 1'b1;
      wire unused_const_in = ^{in_valid[k], in_data[k*WIDTH +: WIDTH]};
    end
`endif
    else begin : g_live
      assign ch_data[k]  = in_data[k*WIDTH +: WIDTH];
      assign ch_valid[k] = in_valid[k];
    end
  end

`ifndef MUX_SEL_PIPE_CONST_EN
  wire unused_const_cfg = ^{CONST_VAL, CONST_CH};
`endif

  logic             load;
  logic             dir_legal;
  logic             scan_found;
  logic [SEL_W-1:0] scan_pick;
  int               scan_cand;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [WIDTH-1:0] data_d;
  logic [SEL_W-1:0] sel_d;
  logic             valid_d, err_d;
  logic [N-1:0]     ack_d;

  assign load      = !out_valid || out_ready;
  assign dir_legal = int'(controle) < N;

  // Round-robin search starting at ptr, wrapping once around the N channels.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    scan_found = 1'b0;
    scan_pick  = '0;
    scan_cand  = 0;
    for (int k = 0; k < N; k++) begin
      scan_cand = int'(ptr) + k;
      if (scan_cand >= N) scan_cand = scan_cand - N;
      if (!scan_found && ch_valid[SEL_W'(scan_cand)]) begin
        scan_found = 1'b1;
        scan_pick  = SEL_W'(scan_cand);
      end
    end
  end

  always_comb begin
    data_d  = out_data;
    valid_d = out_valid;
    sel_d   = out_sel;
    err_d   = sel_err;
    ptr_d   = ptr;
    ack_d   = '0;
    if (load) begin
      if (!mode) begin
        err_d   = !dir_legal;
        valid_d = 1'b0;
        if (dir_legal && ch_valid[controle]) begin
          data_d  = ch_data[controle];
          valid_d = 1'b1;
          sel_d   = controle;
          ack_d   = N'(1) << controle;
        end
      end else begin
        err_d   = 1'b0;
        valid_d = scan_found;
        if (scan_found) begin
          data_d = ch_data[scan_pick];
          sel_d  = scan_pick;
          ack_d  = N'(1) << scan_pick;
          ptr_d  = (int'(scan_pick) == N - 1) ? '0 : scan_pick + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
      in_ack    <= '0;
      ptr       <= '0;
    end else begin
      out_data  <= data_d;
      out_valid <= valid_d;
      out_sel   <= sel_d;
      sel_err   <= err_d;
      in_ack    <= ack_d;
      ptr       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: a behavioural model predicts per-cycle status and transferred words.
module tb_mux_sel_pipe;
  localparam int WIDTH = 32;
  localparam int N     = 5;
  localparam int SEL_W = 3;
  localparam int CONST_CH = 1;
  localparam logic [WIDTH-1:0] CONST_VAL = 32'd4;

  logic               clock = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ack;
  logic [SEL_W-1:0]   controle;
  logic               mode;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SEL_W-1:0]   out_sel;
  logic               sel_err;

  mux_sel_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .CONST_CH(CONST_CH), .CONST_VAL(CONST_VAL)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .controle(controle), .mode(mode), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_sel(out_sel), .sel_err(sel_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             valid;
    logic             err;
    logic [N-1:0]     ack;
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } status_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } word_t;

  status_t sq[$];
  word_t   dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic             m_valid = 1'b0;
  logic             m_err   = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [SEL_W-1:0] m_sel   = '0;
  int               m_ptr   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the result of the coming edge, then advance.
  task automatic step(input logic rst, input logic md, input logic [SEL_W-1:0] ctl,
                      input logic rdy, input logic [N-1:0] vld, input logic [N*WIDTH-1:0] dat);
    logic [WIDTH-1:0] w [N];
    logic [N-1:0]     ev;
    logic [N-1:0]     ack;
    status_t          s;
    int               c;
    reset = rst; mode = md; controle = ctl; out_ready = rdy; in_valid = vld; in_data = dat;
    ev = vld;
    for (int i = 0; i < N; i++) w[i] = dat[i*WIDTH +: WIDTH];
`ifdef MUX_SEL_PIPE_CONST_EN
    ev[CONST_CH] = 1'b1;
    w[CONST_CH]  = CONST_VAL;
`endif
    ack = '0;
    c   = -1;
    if (rst) begin
      m_valid = 1'b0; m_err = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
      dq.delete();
    end else if (!m_valid || rdy) begin
      if (!md) begin
        if (int'(ctl) >= N) m_err = 1'b1;
        else begin
          m_err = 1'b0;
          if (ev[ctl]) c = int'(ctl);
        end
      end else begin
        m_err = 1'b0;
        // Lowest valid channel at or above ptr, otherwise lowest valid channel overall.
        for (int i = 0; i < N; i++) if (c < 0 && ev[i] && i >= m_ptr) c = i;
        for (int i = 0; i < N; i++) if (c < 0 && ev[i]) c = i;
        if (c >= 0) m_ptr = (c + 1) % N;
      end
      m_valid = (c >= 0);
      if (c >= 0) begin
        m_data = w[c];
        m_sel  = SEL_W'(c);
        ack[c] = 1'b1;
        dq.push_back('{data: m_data, sel: m_sel});
      end
    end
    s = '{valid: m_valid, err: m_err, ack: ack, data: m_data, sel: m_sel};
    sq.push_back(s);
    @(posedge clock);
    #2;
  endtask

  // Monitor: per-cycle status plus scoreboard pops on every output transfer.
  always @(negedge clock) begin
    status_t s;
    word_t   wd;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      check("out_valid", 64'(out_valid), 64'(s.valid));
      check("sel_err",   64'(sel_err),   64'(s.err));
      check("in_ack",    64'(in_ack),    64'(s.ack));
      check("out_data",  64'(out_data),  64'(s.data));
      check("out_sel",   64'(out_sel),   64'(s.sel));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
      if (dq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL xfer: unexpected word 0x%0h from channel %0d at %0t", out_data, out_sel, $time);
      end else begin
        wd = dq.pop_front();
        check("xfer_data", 64'(out_data), 64'(wd.data));
        check("xfer_sel",  64'(out_sel),  64'(wd.sel));
      end
    end
  end

  function automatic logic [N*WIDTH-1:0] rand_data();
    logic [N*WIDTH-1:0] d;
    for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  initial begin
    logic [N*WIDTH-1:0] d;
    reset = 1'b1; mode = 1'b0; controle = '0; out_ready = 1'b0; in_valid = '0; in_data = '0;
    #2;
    // Reset with arbitrary inputs
    step(1'b1, 1'b0, 3'd2, 1'b1, 5'b11111, rand_data());
    step(1'b1, 1'b1, 3'd4, 1'b0, 5'b10101, rand_data());

    // Direct select, then three stall cycles, then release
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    step(1'b0, 1'b0, 3'd2, 1'b1, 5'b00100, d);
    repeat (3) step(1'b0, 1'b0, 3'd2, 1'b0, 5'b00100, d);
    step(1'b0, 1'b0, 3'd2, 1'b1, 5'b00000, d);

    // Illegal select code, then a legal one
    d = rand_data();
    d[0 +: WIDTH] = 32'h0000_0011;
    step(1'b0, 1'b0, 3'd6, 1'b1, 5'b11111, d);
    step(1'b0, 1'b0, 3'd7, 1'b1, 5'b11111, d);
    step(1'b0, 1'b0, 3'd0, 1'b1, 5'b00001, d);

    // Scan fairness over channels 0, 3, 4
    repeat (5) step(1'b0, 1'b1, 3'd0, 1'b1, 5'b11001, rand_data());

    // Channel 1 with invalid data (constant channel when the feature is built)
    d = rand_data();
    d[1*WIDTH +: WIDTH] = 32'hFFFFFFFF;
    step(1'b0, 1'b0, 3'd1, 1'b1, 5'b00000, d);

    // Reset during stall clears ptr; next scan starts at channel 0
    step(1'b0, 1'b0, 3'd0, 1'b1, 5'b00001, rand_data());
    step(1'b1, 1'b0, 3'd0, 1'b0, 5'b00001, rand_data());
    step(1'b0, 1'b1, 3'd0, 1'b1, 5'b11111, rand_data());
    step(1'b0, 1'b1, 3'd0, 1'b1, 5'b11111, rand_data());

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, 1'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, 5'($urandom), rand_data());

    // Drain
    repeat (3) step(1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, rand_data());
    @(negedge clock);
    #1;
    check("status_queue_empty", 64'(sq.size()), 64'd0);
    check("word_queue_empty",   64'(dq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
